// File: rtl/vga_pkg.sv
// Shared VGA raster constants and types used by the screen-coordinate processors.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 19;
  localparam int COORD_W      = 10;

  // 640 = 5 << 7, so addr / 640 == (addr >> 7) / 5
  localparam int ROW_SHIFT  = 7;
  localparam int DIV5_MUL   = 3277;
  localparam int DIV5_SHIFT = 14;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/div_by_640.sv
// Combinational exact divide of a frame-buffer address by 640 (quotient = row, remainder = column).
module div_by_640
  import vga_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [COORD_W-1:0] quot_o,
  output logic [COORD_W-1:0] rem_o
);

  localparam int HI_W   = ADDR_W - ROW_SHIFT;
  localparam int PROD_W = HI_W + 12;

  logic [HI_W-1:0]   hi;
  logic [PROD_W-1:0] prod;
  addr_t             rem_full;

  // Reciprocal multiply 3277/2^14 is exact for /5 on any 12-bit operand.
  assign hi     = addr_i[ADDR_W-1:ROW_SHIFT];
  assign prod   = PROD_W'(hi) * PROD_W'(DIV5_MUL);
  assign quot_o = COORD_W'(prod >> DIV5_SHIFT);

  assign rem_full = addr_i - ADDR_W'(quot_o) * ADDR_W'(H_ACTIVE);
  assign rem_o    = COORD_W'(rem_full);

endmodule

// File: rtl/vga_addr_to_cart.sv
// Two-stage pipeline converting a linear VGA address to (x, y) plus an on-screen flag.
module vga_addr_to_cart #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int COORD_W  = vga_pkg::COORD_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  addr,
  output logic               out_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               in_range
);

  logic [COORD_W-1:0] div_quot;
  logic [COORD_W-1:0] div_rem;

  div_by_640 u_div (
    .addr_i (addr),
    .quot_o (div_quot),
    .rem_o  (div_rem)
  );

  // Stage 1
  logic               s1_valid_q;
  logic [ADDR_W-1:0]  s1_addr_q;
  logic [COORD_W-1:0] s1_quot_q;
  logic [COORD_W-1:0] s1_rem_q;

  // NOTE: data registers are reset as well so every output reads 0 while resetn is low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_quot_q  <= '0;
      s1_rem_q   <= '0;
    end else begin
      // NOTE: non-blocking so stage 2 samples stage 1 as it was before this edge.
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_addr_q <= addr;
        s1_quot_q <= div_quot;
        s1_rem_q  <= div_rem;
      end
    end
  end

  // Stage 2
  logic               in_range_d;
  logic               out_valid_q;
  logic               in_range_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;

  assign in_range_d = s1_addr_q < ADDR_W'(H_ACTIVE * V_ACTIVE);

  // Data only advances on a valid beat, so outputs hold between beats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      in_range_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        in_range_q <= in_range_d;
        x_q        <= s1_rem_q;
        y_q        <= s1_quot_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign in_range  = in_range_q;
  assign x         = x_q;
  assign y         = y_q;

endmodule

// File: tb/tb_vga_addr_to_cart.sv
// Scoreboard bench for vga_addr_to_cart: expected beats queued at drive time, popped on out_valid.
module tb_vga_addr_to_cart;

  localparam int ADDR_W  = 19;
  localparam int COORD_W = 10;

  logic               clock    = 1'b0;
  logic               resetn   = 1'b1;
  logic               in_valid = 1'b0;
  logic [ADDR_W-1:0]  addr     = '0;
  logic               out_valid;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               in_range;

  vga_addr_to_cart dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .addr      (addr),
    .out_valid (out_valid),
    .x         (x),
    .y         (y),
    .in_range  (in_range)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int a;
    int ex;
    int ey;
    bit ei;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Queue a beat with explicit expectations; called #1 after a rising edge.
  task automatic push_exp(int a, int ex, int ey, bit ei);
    exp_t e;
    in_valid = 1'b1;
    addr     = ADDR_W'(a);
    e.a = a; e.ex = ex; e.ey = ey; e.ei = ei; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic push_model(int a);
    push_exp(a, a % 640, a / 640, a < 307200);
  endtask

  task automatic step(bit v, int a);
    @(posedge clock);
    #1;
    if (v) push_model(a);
    else   in_valid = 1'b0;
  endtask

  // Scoreboard monitor: order, values, exact latency, no extra or missing beats.
  exp_t m;
  always @(negedge clock) begin
    if (resetn) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        m = sb.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_beat addr=%0d due_cycle=%0d now=%0d", m.a, m.due, cyc);
      end
      if (out_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL extra_beat got x=%0d y=%0d in_range=%0b, none expected", x, y, in_range);
        end else begin
          m = sb.pop_front();
          if ({x, y, in_range} !== {COORD_W'(m.ex), COORD_W'(m.ey), m.ei} || cyc != m.due) begin
            n_errors++;
            $display("FAIL beat addr=%0d got x=%0d y=%0d ir=%0b cyc=%0d, want x=%0d y=%0d ir=%0b cyc=%0d",
                     m.a, x, y, in_range, cyc, m.ex, m.ey, m.ei, m.due);
          end
        end
      end
    end
  end

  task automatic test_reset;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, x, y, in_range} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%0b x=%0d y=%0d ir=%0b, want all 0", out_valid, x, y, in_range);
    end
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({out_valid, x, y, in_range} !== '0) begin
      n_errors++;
      $display("FAIL reset_hold got v=%0b x=%0d y=%0d ir=%0b, want all 0", out_valid, x, y, in_range);
    end
    // First beat is presented for the very first edge after release.
    resetn = 1'b1;
    push_exp(0, 0, 0, 1'b1);
  endtask

  task automatic test_corners;
    @(posedge clock); #1 push_exp(639, 639, 0, 1'b1);
    @(posedge clock); #1 push_exp(640, 0, 1, 1'b1);
    @(posedge clock); #1 push_exp(307199, 639, 479, 1'b1);
    @(posedge clock); #1 push_exp(307200, 0, 480, 1'b0);
    @(posedge clock); #1 push_exp(524287, 127, 819, 1'b0);
    repeat (4) step(1'b0, 0);
  endtask

  task automatic test_hold;
    @(posedge clock); #1 push_exp(25940, 340, 40, 1'b1);
    repeat (3) step(1'b0, 0);
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b0 || x !== 10'd340 || y !== 10'd40 || in_range !== 1'b1) begin
        n_errors++;
        $display("FAIL hold got v=%0b x=%0d y=%0d ir=%0b, want v=0 x=340 y=40 ir=1", out_valid, x, y, in_range);
      end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = $urandom_range(524287 - 1000, 0);
    for (int i = 0; i < 1000; i++) step(1'b1, base + i);
    for (int i = 0; i < 300; i++) step($urandom_range(1, 0) == 1, $urandom_range(524287, 0));
    repeat (4) step(1'b0, 0);
  endtask

  // Every row-block value, at both ends of each 128-address block, plus a random offset.
  task automatic test_sweep;
    for (int hi = 0; hi < 4096; hi++) begin
      step(1'b1, hi * 128);
      step(1'b1, hi * 128 + 127);
      if (hi % 16 == 0) step(1'b1, hi * 128 + $urandom_range(127, 0));
    end
    repeat (4) step(1'b0, 0);
  endtask

  task automatic test_midstream_reset;
    for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(524287, 1000));
    #3;
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, x, y, in_range} !== '0) begin
      n_errors++;
      $display("FAIL async_reset got v=%0b x=%0d y=%0d ir=%0b, want all 0", out_valid, x, y, in_range);
    end
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    push_model(640 * 7 + 5);
    repeat (6) step(1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_hold();
    test_back_to_back();
    test_sweep();
    test_midstream_reset();
    repeat (5) step(1'b0, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending beats, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
